// File: rtl/comp_pkg.sv
// Shared LZRW1 constants, copy-item layout and decompressor state encoding.
package comp_pkg;

  localparam int unsigned HIST_BITS = 12;
  localparam int unsigned HISTORY   = 1 << HIST_BITS;
  localparam int unsigned LEN_BIAS  = 3;
  localparam int unsigned CTRL_BITS = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned OFF_HI_W  = 4;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned REM_BITS  = 5;
  localparam int unsigned PROD_BITS = 13;

  // First byte of a copy item: offset[11:8] in the high nibble, length-3 in the low nibble.
  typedef struct packed {
    logic [OFF_HI_W-1:0] off_hi;
    logic [LEN_W-1:0]    len_code;
  } copy_b0_t;

  typedef enum logic [2:0] {
    CTRL_LO,
    CTRL_HI,
    ITEM,
    LIT,
    COPY_B0,
    COPY_B1,
    COPY,
    ERR
  } decomp_state_t;

  function automatic decomp_state_t item_state(input logic is_copy);
    return is_copy ? COPY_B0 : LIT;
  endfunction

endpackage

// File: rtl/decomp_history.sv
// Sliding-window history: one synchronous write port, one combinational read port.
module decomp_history
  import comp_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [HIST_BITS-1:0] waddr,
  input  logic [BYTE_W-1:0]    wdata,
  input  logic [HIST_BITS-1:0] raddr,
  output logic [BYTE_W-1:0]    rdata
);

  logic [BYTE_W-1:0] mem_q [HISTORY];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/decomp_output.sv
// LZRW1 decompressor output stage: parses control words, literals and copy items
// and replays bytes from the history onto a registered valid/ready byte port.
module decomp_output
  import comp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err
);

  decomp_state_t        state_q, state_d;
  logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  copy_b0_t             b0_q, b0_d;
  logic [HIST_BITS-1:0] off_q, off_d;
  logic [REM_BITS-1:0]  rem_q, rem_d;
  logic                 blk_last_q, blk_last_d;
  logic [HIST_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PROD_BITS-1:0] produced_q, produced_d;
  logic [BYTE_W-1:0]    out_byte_q, out_byte_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 err_q, err_d;

  logic                 free_c, ready_c, emit_c, emit_last_c, item_done_c;
  logic [BYTE_W-1:0]    emit_byte_c, hist_rdata_c;
  logic [HIST_BITS-1:0] copy_off_c, rd_ptr_c;

  assign free_c     = !out_valid_q || out_ready;
  assign copy_off_c = {b0_q.off_hi, in_byte};
  assign rd_ptr_c   = wr_ptr_q - off_q;
  assign in_ready   = ready_c && rst_n;
  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign err        = err_q;

  decomp_history u_hist (
    .clk   (clk),
    .we    (emit_c),
    .waddr (wr_ptr_q),
    .wdata (emit_byte_c),
    .raddr (rd_ptr_c),
    .rdata (hist_rdata_c)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    bit_cnt_d   = bit_cnt_q;
    b0_d        = b0_q;
    off_d       = off_q;
    rem_d       = rem_q;
    blk_last_d  = blk_last_q;
    wr_ptr_d    = wr_ptr_q;
    produced_d  = produced_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q && out_valid_d;
    err_d       = err_q;
    ready_c     = 1'b0;
    emit_c      = 1'b0;
    emit_byte_c = in_byte;
    emit_last_c = 1'b0;
    item_done_c = 1'b0;

    unique case (state_q)
      CTRL_LO: begin
        ready_c = 1'b1;
        if (in_valid) begin
          ctrl_d[BYTE_W-1:0] = in_byte;
          state_d = in_last ? ERR : CTRL_HI;
        end
      end
      CTRL_HI: begin
        ready_c = 1'b1;
        if (in_valid) begin
          ctrl_d[CTRL_BITS-1:BYTE_W] = in_byte;
          bit_cnt_d = '0;
          state_d   = in_last ? ERR : item_state(ctrl_q[0]);
        end
      end
      ITEM: begin
        state_d = item_state(ctrl_q[bit_cnt_q]);
      end
      LIT: begin
        ready_c = free_c;
        if (in_valid && free_c) begin
          emit_c      = 1'b1;
          emit_last_c = in_last;
          item_done_c = 1'b1;
        end
      end
      COPY_B0: begin
        ready_c = 1'b1;
        if (in_valid) begin
          b0_d    = copy_b0_t'(in_byte);
          state_d = in_last ? ERR : COPY_B1;
        end
      end
      COPY_B1: begin
        ready_c = 1'b1;
        if (in_valid) begin
          // Offset must point inside bytes already produced in this block.
          if (copy_off_c == '0 || PROD_BITS'(copy_off_c) > produced_q) begin
            state_d = ERR;
          end else begin
            off_d      = copy_off_c;
            rem_d      = REM_BITS'(b0_q.len_code) + REM_BITS'(LEN_BIAS);
            blk_last_d = in_last;
            state_d    = COPY;
          end
        end
      end
      COPY: begin
        if (free_c) begin
          emit_c      = 1'b1;
          emit_byte_c = hist_rdata_c;
          emit_last_c = blk_last_q && (rem_q == REM_BITS'(1));
          item_done_c = (rem_q == REM_BITS'(1));
          rem_d       = rem_q - REM_BITS'(1);
        end
      end
      ERR: begin
      end
      default: state_d = ERR;
    endcase

    // Every emitted byte lands in the output register and the history on the same edge.
    if (emit_c) begin
      out_byte_d  = emit_byte_c;
      out_valid_d = 1'b1;
      out_last_d  = emit_last_c;
      wr_ptr_d    = wr_ptr_q + HIST_BITS'(1);
      produced_d  = (&produced_q) ? produced_q : produced_q + PROD_BITS'(1);
    end

    // Final byte already sits in the output register, so the next block may start parsing.
    if (item_done_c) begin
      if (emit_last_c) begin
        state_d    = CTRL_LO;
        bit_cnt_d  = '0;
        wr_ptr_d   = '0;
        produced_d = '0;
      end else if (bit_cnt_q == '1) begin
        state_d   = CTRL_LO;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        state_d   = item_state(ctrl_q[bit_cnt_q + BIT_CNT_W'(1)]);
      end
    end

    if (state_d == ERR) begin
      err_d       = 1'b1;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CTRL_LO;
      ctrl_q      <= '0;
      bit_cnt_q   <= '0;
      b0_q        <= '0;
      off_q       <= '0;
      rem_q       <= '0;
      blk_last_q  <= 1'b0;
      wr_ptr_q    <= '0;
      produced_q  <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      bit_cnt_q   <= bit_cnt_d;
      b0_q        <= b0_d;
      off_q       <= off_d;
      rem_q       <= rem_d;
      blk_last_q  <= blk_last_d;
      wr_ptr_q    <= wr_ptr_d;
      produced_q  <= produced_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_decomp_output.sv
// Bench for decomp_output: directed and random LZRW1 blocks checked against a
// software-style byte-stream decoder kept in the bench.
module tb_decomp_output;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_byte;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_byte;
  logic       out_valid, out_last, out_ready, err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0] stream_q[$];
  logic [7:0] exp_q[$];
  bit         exp_err, exp_last;
  int         acc_cyc [16384];
  int         out_cyc [16384];

  always #5 clk = ~clk;

  decomp_output dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stream_q.push_back(v[8*k +: 8]);
  endtask

  // Reference decoder: walks the whole block, final byte carries in_last.
  function automatic void model();
    int i, n, off, len;
    logic [15:0] ctrl;
    exp_q.delete();
    exp_err = 1'b0;
    i = 0;
    n = stream_q.size();
    while (i < n && !exp_err) begin
      if (i >= n - 2) begin
        exp_err = 1'b1;
        break;
      end
      ctrl = {stream_q[i+1], stream_q[i]};
      i += 2;
      for (int b = 0; b < 16 && i < n && !exp_err; b++) begin
        if (!ctrl[b]) begin
          exp_q.push_back(stream_q[i]);
          i++;
        end else if (i >= n - 1) begin
          exp_err = 1'b1;
        end else begin
          off = int'({stream_q[i][7:4], stream_q[i+1]});
          len = int'(stream_q[i][3:0]) + 3;
          i += 2;
          if (off == 0 || off > exp_q.size()) exp_err = 1'b1;
          else for (int k = 0; k < len; k++) exp_q.push_back(exp_q[exp_q.size() - off]);
        end
      end
    end
    exp_last = !exp_err;
  endfunction

  function automatic void gen_random(input int n_items, input int lit_first, input int far_pct);
    logic [7:0]  grp[$];
    logic [15:0] ctrl;
    int prod, b, off, lc, maxo;
    stream_q.delete();
    prod = 0;
    b    = 0;
    ctrl = '0;
    for (int it = 0; it < n_items; it++) begin
      if (it >= lit_first && prod > 0 && $urandom_range(0, 2) == 0) begin
        maxo = (prod > 4095) ? 4095 : prod;
        if (prod >= 4095 && int'($urandom_range(0, 99)) < far_pct) off = 4095;
        else off = int'($urandom_range(1, maxo));
        lc = int'($urandom_range(0, 15));
        ctrl[b] = 1'b1;
        grp.push_back({4'(off >> 8), 4'(lc)});
        grp.push_back(8'(off));
        prod += lc + 3;
      end else begin
        grp.push_back(8'($urandom));
        prod++;
      end
      b++;
      if (b == 16 || it == n_items - 1) begin
        stream_q.push_back(ctrl[7:0]);
        stream_q.push_back(ctrl[15:8]);
        foreach (grp[k]) stream_q.push_back(grp[k]);
        grp.delete();
        ctrl = '0;
        b    = 0;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 alternating. stop_at>0 abandons after that many outputs.
  task automatic run_block(input int rdy_mode, input bit gaps, input int budget, input int stop_at);
    int si, oi, cyc;
    bit done;
    si = 0; oi = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      in_valid = (si < stream_q.size()) && (!gaps || $urandom_range(0, 3) != 0);
      in_byte  = (si < stream_q.size()) ? stream_q[si] : 8'h00;
      in_last  = (si == stream_q.size() - 1);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (cyc % 2 == 0);
      endcase
      #1;
      if (out_valid && out_ready) begin
        if (oi < exp_q.size()) begin
          check("out_byte", 32'(out_byte), 32'(exp_q[oi]));
          check("out_last", 32'(out_last), 32'(exp_last && (oi == exp_q.size() - 1)));
          if (oi < 16384) out_cyc[oi] = cyc;
        end else begin
          check("extra_out", 32'(out_valid), 0);
        end
        oi++;
      end
      if (in_valid && in_ready) begin
        if (si < 16384) acc_cyc[si] = cyc;
        si++;
      end
      cyc++;
      done = (si >= stream_q.size() && oi >= exp_q.size()) || (stop_at > 0 && oi >= stop_at);
    end
    check("block_done", 32'(done), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_err_end();
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    #1;
    check("err_flag", 32'(err), 32'(exp_err));
    check("err_in_ready", 32'(in_ready), 0);
    check("err_out_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_byte", 32'(out_byte), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Literals only, latency 1 each.
    stream_q.delete(); push_bytes(64'h0000414243, 5); model();
    run_block(0, 1'b0, 200, 0);
    for (int k = 0; k < 3; k++) check("lit_latency", 32'(out_cyc[k] - acc_cyc[k+2]), 1);
    check("lit_err", 32'(err), 32'(exp_err));

    // Overlapping copy, offset 1 length 5.
    stream_q.delete(); push_bytes(64'h0200410201, 5); model();
    run_block(0, 1'b0, 200, 0);
    check("ovl_lit_latency", 32'(out_cyc[0] - acc_cyc[2]), 1);
    check("ovl_copy_latency", 32'(out_cyc[1] - acc_cyc[4]), 2);
    for (int k = 1; k < 5; k++) check("ovl_back_to_back", 32'(out_cyc[k+1] - out_cyc[k]), 1);

    // 18 literals, then copy offset 18 length 18; full rate then alternating out_ready.
    for (int pass = 0; pass < 2; pass++) begin
      stream_q.delete();
      push_bytes(64'h0000, 2);
      for (int k = 0; k < 16; k++) stream_q.push_back(8'(8'h10 + k));
      push_bytes(64'h0400, 2);
      stream_q.push_back(8'h20);
      stream_q.push_back(8'h21);
      push_bytes(64'h0F12, 2);
      model();
      run_block(pass == 0 ? 0 : 2, 1'b0, 400, 0);
      if (pass == 0) begin
        check("max_copy_latency", 32'(out_cyc[18] - acc_cyc[23]), 2);
        check("max_copy_span", 32'(out_cyc[35] - out_cyc[18]), 17);
      end
      check("max_copy_err", 32'(err), 32'(exp_err));
    end

    // Random back-to-back blocks with control rollover, stalls and input gaps.
    for (int r = 0; r < 6; r++) begin
      gen_random(int'($urandom_range(10, 60)), 0, 0);
      model();
      run_block(1, 1'b1, 5000, 0);
      check("rand_err", 32'(err), 32'(exp_err));
    end

    // Long block: history wraps, many offset-4095 copies.
    gen_random(4400, 4095, 50);
    model();
    run_block(1, 1'b0, 60000, 0);
    check("wrap_err", 32'(err), 32'(exp_err));

    // Error cases.
    for (int e = 0; e < 5; e++) begin
      do_reset();
      stream_q.delete();
      case (e)
        0: push_bytes(64'h0200410000, 5);
        1: push_bytes(64'h08004142430005, 7);
        2: push_bytes(64'h00, 1);
        3: push_bytes(64'h0000, 2);
        default: push_bytes(64'h010005, 3);
      endcase
      model();
      run_block(0, 1'b0, 200, 0);
      check_err_end();
    end

    // Reset in the middle of a copy, then a fresh block.
    do_reset();
    stream_q.delete(); push_bytes(64'h0200410F01, 5); model();
    run_block(0, 1'b0, 200, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_byte", 32'(out_byte), 0);
    check("midrst_out_last", 32'(out_last), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    check("midrst_hold_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    stream_q.delete(); push_bytes(64'h0000414243, 5); model();
    run_block(0, 1'b0, 200, 0);
    check("post_rst_latency", 32'(out_cyc[0] - acc_cyc[2]), 1);
    check("post_rst_err", 32'(err), 32'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
